// File: rtl/sweep_pkg.sv
// Shared types and helpers for the multi-channel sweep counter bank.
// Config fields are carried at fixed maximum widths (limit up to 32 bits,
// step up to 16 bits) so the package stays independent of CBITS/STEP_BITS.
package sweep_pkg;

    localparam int unsigned SWEEP_LIMIT_W = 32;
    localparam int unsigned SWEEP_STEP_W  = 16;
    localparam int unsigned SWEEP_ARITH_W = SWEEP_LIMIT_W + 1;

    localparam logic MODE_TRI_ENC = 1'b0;
    localparam logic MODE_SAW_ENC = 1'b1;

    typedef enum logic {
        SWEEP_TRI = MODE_TRI_ENC,
        SWEEP_SAW = MODE_SAW_ENC
    } sweep_mode_e;

    typedef struct packed {
        logic [SWEEP_LIMIT_W-1:0] limit;
        sweep_mode_e              mode;
        logic [SWEEP_STEP_W-1:0]  step;
    } sweep_cfg_t;

    // A programmed step of zero advances by one.
    function automatic logic [SWEEP_STEP_W-1:0] eff_step(input logic [SWEEP_STEP_W-1:0] step);
        return (step == '0) ? SWEEP_STEP_W'(1) : step;
    endfunction

    // A programmed limit of zero sweeps between 0 and 1.
    function automatic logic [SWEEP_LIMIT_W-1:0] eff_limit(input logic [SWEEP_LIMIT_W-1:0] limit);
        return (limit == '0) ? SWEEP_LIMIT_W'(1) : limit;
    endfunction

endpackage

// File: rtl/sweep_channel.sv
// One sweep channel: config registers, count/direction state and strobes.
module sweep_channel
    import sweep_pkg::*;
#(
    parameter int unsigned CBITS     = 16,
    parameter int unsigned DEF_LIMIT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  sweep_cfg_t       cfg_in,
    input  logic             restart,
    input  logic             en,
    output logic [CBITS-1:0] count,
    output logic             dir_up,
    output logic             peak,
    output logic             trough
);

    localparam int unsigned AW = SWEEP_ARITH_W;
    localparam sweep_cfg_t CFG_RST = '{
        limit: SWEEP_LIMIT_W'(DEF_LIMIT),
        mode:  SWEEP_TRI,
        step:  SWEEP_STEP_W'(1)
    };

    sweep_cfg_t       cfg_q;
    sweep_cfg_t       cfg_n;
    logic [CBITS-1:0] count_n;
    logic             dir_n;
    logic             peak_n;
    logic             trough_n;
    logic [AW-1:0]    lim;
    logic [AW-1:0]    stp;
    logic [AW-1:0]    cur;
    logic [AW-1:0]    sum;

    // State and config registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q  <= CFG_RST;
            count  <= '0;
            dir_up <= 1'b1;
            peak   <= 1'b0;
            trough <= 1'b0;
        end else begin
            cfg_q  <= cfg_n;
            count  <= count_n;
            dir_up <= dir_n;
            peak   <= peak_n;
            trough <= trough_n;
        end
    end

    // Next-state: config write / restart first, then triangle or sawtooth step.
    always_comb begin
        cfg_n    = cfg_q;
        count_n  = count;
        dir_n    = dir_up;
        peak_n   = 1'b0;
        trough_n = 1'b0;
        lim      = AW'(eff_limit(cfg_q.limit));
        stp      = AW'(eff_step(cfg_q.step));
        cur      = AW'(count);
        sum      = cur + stp;

        if (cfg_we) begin
            cfg_n = cfg_in;
        end

        if (cfg_we || restart) begin
            count_n = '0;
            dir_n   = 1'b1;
        end else if (en) begin
            if (cfg_q.mode == SWEEP_SAW) begin
                dir_n = 1'b1;
                if (cur == lim) begin
                    count_n  = '0;
                    trough_n = 1'b1;
                end else if (sum >= lim) begin
                    count_n = CBITS'(lim);
                    peak_n  = 1'b1;
                end else begin
                    count_n = CBITS'(sum);
                end
            end else if (dir_up) begin
                if (sum >= lim) begin
                    count_n = CBITS'(lim);
                    peak_n  = 1'b1;
                    dir_n   = 1'b0;
                end else begin
                    count_n = CBITS'(sum);
                end
            end else begin
                if (cur <= stp) begin
                    count_n  = '0;
                    trough_n = 1'b1;
                    dir_n    = 1'b1;
                end else begin
                    count_n = CBITS'(cur - stp);
                end
            end
        end
    end

endmodule

// File: rtl/multi_sweep_counter.sv
// NCH-channel triangle/sawtooth sweep counter bank.
// Optional SWEEP_SYNC_EN adds sync_all, which restarts every channel at once.
module multi_sweep_counter
    import sweep_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CBITS     = 16,
    parameter int unsigned DEF_LIMIT = 50000,
    parameter int unsigned STEP_BITS = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  cfg_ch,
    input  logic [CBITS-1:0]                          cfg_limit,
    input  logic                                      cfg_mode,
    input  logic [STEP_BITS-1:0]                      cfg_step,
    input  logic [NCH-1:0]                            en,
`ifdef SWEEP_SYNC_EN
    input  logic                                      sync_all,
`endif
    output logic [NCH*CBITS-1:0]                      count,
    output logic [NCH-1:0]                            dir_up,
    output logic [NCH-1:0]                            peak,
    output logic [NCH-1:0]                            trough
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    sweep_cfg_t cfg_bus;
    logic       sync_c;

    assign cfg_bus = '{
        limit: SWEEP_LIMIT_W'(cfg_limit),
        mode:  sweep_mode_e'(cfg_mode),
        step:  SWEEP_STEP_W'(cfg_step)
    };

`ifdef SWEEP_SYNC_EN
    assign sync_c = sync_all;
`else
    assign sync_c = 1'b0;
`endif

    // Per-channel write decode; out-of-range channel numbers match nothing.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic we_c;
        assign we_c = cfg_we && (cfg_ch == CHW'(i));

        sweep_channel #(
            .CBITS     (CBITS),
            .DEF_LIMIT (DEF_LIMIT)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .cfg_we  (we_c),
            .cfg_in  (cfg_bus),
            .restart (sync_c),
            .en      (en[i]),
            .count   (count[i*CBITS +: CBITS]),
            .dir_up  (dir_up[i]),
            .peak    (peak[i]),
            .trough  (trough[i])
        );
    end

endmodule

// File: tb/tb_multi_sweep_counter.sv
// Directed, table-driven bench for multi_sweep_counter (NCH=4, CBITS=16).
module tb_multi_sweep_counter;

    localparam int NCH   = 4;
    localparam int CBITS = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [CBITS-1:0]     cfg_limit;
    logic                 cfg_mode;
    logic [3:0]           cfg_step;
    logic [NCH-1:0]       en;
`ifdef SWEEP_SYNC_EN
    logic                 sync_all;
`endif
    logic [NCH*CBITS-1:0] count;
    logic [NCH-1:0]       dir_up;
    logic [NCH-1:0]       peak;
    logic [NCH-1:0]       trough;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_sweep_counter #(
        .NCH       (NCH),
        .CBITS     (CBITS),
        .DEF_LIMIT (50000),
        .STEP_BITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_limit (cfg_limit),
        .cfg_mode  (cfg_mode),
        .cfg_step  (cfg_step),
        .en        (en),
`ifdef SWEEP_SYNC_EN
        .sync_all  (sync_all),
`endif
        .count     (count),
        .dir_up    (dir_up),
        .peak      (peak),
        .trough    (trough)
    );

    typedef struct {
        bit         adv;
        bit         we;
        logic [1:0] ch;
        logic [15:0] lim;
        logic       mode;
        logic [3:0] stp;
        logic [3:0] en;
        int         chk;
        logic [15:0] ec;
        logic       ed;
        logic       ep;
        logic       et;
    } vec_t;

    vec_t vq[$];

    // Append one vector: inputs (applied over one edge when adv=1), then the
    // expected state of channel chk.
    function automatic void row(input int adv, input int we, input int ch, input int lim,
                                input int mode, input int stp, input int e, input int chk,
                                input int ec, input int ed, input int ep, input int et);
        vec_t v;
        v.adv  = (adv != 0);
        v.we   = (we != 0);
        v.ch   = 2'(ch);
        v.lim  = 16'(lim);
        v.mode = (mode != 0);
        v.stp  = 4'(stp);
        v.en   = 4'(e);
        v.chk  = chk;
        v.ec   = 16'(ec);
        v.ed   = (ed != 0);
        v.ep   = (ep != 0);
        v.et   = (et != 0);
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int ch, input int ec,
                         input int ed, input int ep, input int et);
        logic [15:0] c;
        c = count[ch*CBITS +: CBITS];
        checks++;
        if (c !== 16'(ec) || dir_up[ch] !== (ed != 0) ||
            peak[ch] !== (ep != 0) || trough[ch] !== (et != 0)) begin
            errors++;
            $display("FAIL %s ch%0d: got count=%0d dir=%b pk=%b tr=%b, want count=%0d dir=%0d pk=%0d tr=%0d",
                     name, ch, c, dir_up[ch], peak[ch], trough[ch], ec, ed, ep, et);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit bad;

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0;
        cfg_mode = 1'b0; cfg_step = '0; en = '0;
`ifdef SWEEP_SYNC_EN
        sync_all = 1'b0;
`endif

        // Triangle ch0: limit 5 step 2.
        row(1,1,0,5,0,2,'h0, 0, 0,1,0,0);
        row(1,0,0,0,0,0,'h1, 0, 2,1,0,0);
        row(1,0,0,0,0,0,'h1, 0, 4,1,0,0);
        row(1,0,0,0,0,0,'h1, 0, 5,0,1,0);
        row(1,0,0,0,0,0,'h1, 0, 3,0,0,0);
        row(1,0,0,0,0,0,'h1, 0, 1,0,0,0);
        row(1,0,0,0,0,0,'h1, 0, 0,1,0,1);
        row(1,0,0,0,0,0,'h1, 0, 2,1,0,0);
        row(1,0,0,0,0,0,'h1, 0, 4,1,0,0);
        row(1,0,0,0,0,0,'h1, 0, 5,0,1,0);
        // Sawtooth ch1: limit 4 step 1, peak every 5 cycles.
        row(1,1,1,4,1,1,'h0, 1, 0,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 1,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 2,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 3,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 4,1,1,0);
        row(1,0,0,0,0,0,'h2, 1, 0,1,0,1);
        row(1,0,0,0,0,0,'h2, 1, 1,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 2,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 3,1,0,0);
        row(1,0,0,0,0,0,'h2, 1, 4,1,1,0);
        row(0,0,0,0,0,0,'h2, 0, 5,0,0,0);
        // Both running; then a config write to ch0 at count 3 restarts it only.
        row(1,0,0,0,0,0,'h3, 0, 3,0,0,0);
        row(0,0,0,0,0,0,'h3, 1, 0,1,0,1);
        row(1,1,0,5,0,2,'h3, 0, 0,1,0,0);
        row(0,0,0,0,0,0,'h3, 1, 1,1,0,0);
        row(1,0,0,0,0,0,'h3, 0, 2,1,0,0);
        row(0,0,0,0,0,0,'h3, 1, 2,1,0,0);
        // ch2 enable held low for 3 cycles at count 7.
        row(1,1,2,20,0,1,'h0, 2, 0,1,0,0);
        for (int k = 1; k <= 7; k++) row(1,0,0,0,0,0,'h4, 2, k,1,0,0);
        for (int k = 0; k < 3; k++)  row(1,0,0,0,0,0,'h0, 2, 7,1,0,0);
        row(1,0,0,0,0,0,'h4, 2, 8,1,0,0);
        // ch2 step larger than limit bounces directly between 0 and limit.
        row(1,1,2,3,0,7,'h0, 2, 0,1,0,0);
        row(1,0,0,0,0,0,'h4, 2, 3,0,1,0);
        row(1,0,0,0,0,0,'h4, 2, 0,1,0,1);
        row(1,0,0,0,0,0,'h4, 2, 3,0,1,0);
        // ch3 step 0 / limit 0 acts as step 1 / limit 1, triangle then sawtooth.
        row(1,1,3,0,0,0,'h0, 3, 0,1,0,0);
        row(1,0,0,0,0,0,'h8, 3, 1,0,1,0);
        row(1,0,0,0,0,0,'h8, 3, 0,1,0,1);
        row(1,0,0,0,0,0,'h8, 3, 1,0,1,0);
        row(1,0,0,0,0,0,'h8, 3, 0,1,0,1);
        row(1,1,3,0,1,0,'h8, 3, 0,1,0,0);
        row(1,0,0,0,0,0,'h8, 3, 1,1,1,0);
        row(1,0,0,0,0,0,'h8, 3, 0,1,0,1);
        row(1,0,0,0,0,0,'h8, 3, 1,1,1,0);

        // Reset state.
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) check("reset", i, 0, 1, 0, 0);

        // Default limit: ch0 climbs by one per cycle, first peak at 50000.
        en = 4'h1;
        bad = 1'b0;
        for (int k = 1; k < 50000; k++) begin
            tick();
            if (count[15:0] !== 16'(k) || peak[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL default_ramp: got count=%0d pk=%b, want steady ramp with no peak before 50000",
                     count[15:0], peak[0]);
        end
        tick();
        check("default_peak", 0, 50000, 0, 1, 0);
        tick();
        check("default_down", 0, 49999, 0, 0, 0);

        // Table vectors.
        foreach (vq[i]) begin
            if (vq[i].adv) begin
                cfg_we    = vq[i].we;
                cfg_ch    = vq[i].ch;
                cfg_limit = vq[i].lim;
                cfg_mode  = vq[i].mode;
                cfg_step  = vq[i].stp;
                en        = vq[i].en;
                tick();
                cfg_we    = 1'b0;
            end
            check($sformatf("vec%0d", i), vq[i].chk, int'(vq[i].ec),
                  int'(vq[i].ed), int'(vq[i].ep), int'(vq[i].et));
        end

        // Reset mid-sweep, with a config write pending: rst wins.
        en = 4'hF;
        tick(); tick();
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_limit = 16'd9;
        tick();
        rst = 1'b0; cfg_we = 1'b0;
        for (int i = 0; i < NCH; i++) check("rst_mid", i, 0, 1, 0, 0);
        // Limits are back to 50000: ch2 (was 3) and ch3 (was 0) keep ramping.
        en = 4'hC;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("rst_lim2", 2, k, 1, 0, 0);
            check("rst_lim3", 3, k, 1, 0, 0);
        end

`ifdef SWEEP_SYNC_EN
        // sync_all zeroes every channel but a simultaneous write still lands.
        en = 4'hF;
        tick(); tick();
        sync_all = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1;
        cfg_limit = 16'd2; cfg_mode = 1'b0; cfg_step = 4'd1;
        tick();
        sync_all = 1'b0; cfg_we = 1'b0;
        for (int i = 0; i < NCH; i++) check("sync", i, 0, 1, 0, 0);
        en = 4'h2;
        tick();
        check("sync_cfg1", 1, 1, 1, 0, 0);
        tick();
        check("sync_cfg2", 1, 2, 0, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
